// File: rtl/sqm_pkg.sv
// sqm_pkg: shared types and constants for the PSG (capcom-style) bus writer.
//   state_t  - bus-writer FSM states
//   cmd_t    - queued command payload {register index, data}
//   ADR_*    - bus_adr phase encodings
//   DEF_*    - default timing / depth parameters
package sqm_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = REG_W + DATA_W;

  localparam int unsigned DEF_DEPTH    = 4;
  localparam int unsigned DEF_WR_WIDTH = 2;
  localparam int unsigned DEF_GAP      = 8;

  localparam logic ADR_INDEX = 1'b0;
  localparam logic ADR_DATA  = 1'b1;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_GAP
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sqm_cmd_fifo.sv
// sqm_cmd_fifo: command FIFO, DEPTH entries of cmd_t (12 bits).
//   clk, reset     - clock, async active-high reset (empties the FIFO)
//   push, wdata    - write request and payload (ignored while full)
//   pop, rdata     - read request and head-of-queue payload (ignored while empty)
//   full, empty    - occupancy flags
module sqm_cmd_fifo
  import sqm_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit separates full (wrapped once more) from empty.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sqm_bus_writer.sv
// sqm_bus_writer: queues {register, data} commands and replays each one as an
// index write followed by a data write on a PSG-style bus, then idles GAP cycles.
//   clk, reset                      - clock, async active-high reset
//   cmd_valid, cmd_reg, cmd_data    - command input (accepted when cmd_ready)
//   cmd_ready                       - FIFO not full
//   bus_adr, bus_dout               - latch select (index/data) and bus data
//   bus_cs_n, bus_wr_n              - active-low chip select and write strobe
//   busy                            - FIFO non-empty or a command in flight
module sqm_bus_writer
  import sqm_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned WR_WIDTH = DEF_WR_WIDTH,
  parameter int unsigned GAP      = DEF_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [REG_W-1:0]  cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              bus_adr,
  output logic [DATA_W-1:0] bus_dout,
  output logic              bus_cs_n,
  output logic              bus_wr_n,
  output logic              busy
);

  localparam int unsigned CNT_MAX = max_u(max_u(WR_WIDTH, GAP), 1);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP == 0) ? 0 : GAP - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  cmd_t             cur;
  cmd_t             fifo_head;
  cmd_t             push_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_c;

  assign push_cmd  = {cmd_reg, cmd_data};
  assign cmd_ready = !fifo_full;

  // Pop from IDLE, or straight out of the final idle cycle of a command so
  // back-to-back commands run with no extra IDLE bubble.
  assign pop_c = !fifo_empty &&
                 ((state == ST_IDLE) ||
                  ((state == ST_D_HOLD) && (GAP == 0)) ||
                  ((state == ST_GAP) && (cnt == GAP_LAST)));

  sqm_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (push_cmd),
    .pop   (pop_c),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bus FSM; outputs are registered from the state held during the cycle, so
  // bus_adr/bus_dout only load while in A_SETUP/D_SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur      <= '0;
      bus_adr  <= ADR_INDEX;
      bus_dout <= '0;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy     <= (state != ST_IDLE) || !fifo_empty;
      bus_cs_n <= 1'b1;
      bus_wr_n <= 1'b1;
      if (pop_c) cur <= fifo_head;
      case (state)
        ST_IDLE: begin
          if (pop_c) state <= ST_A_SETUP;
        end
        ST_A_SETUP: begin
          bus_adr  <= ADR_INDEX;
          bus_dout <= DATA_W'(cur.idx);
          bus_cs_n <= 1'b0;
          cnt      <= '0;
          state    <= ST_A_STROBE;
        end
        ST_A_STROBE: begin
          bus_cs_n <= 1'b0;
          bus_wr_n <= 1'b0;
          if (cnt == WR_LAST) state <= ST_A_HOLD;
          else                cnt   <= cnt + CNT_W'(1);
        end
        ST_A_HOLD: begin
          bus_cs_n <= 1'b0;
          state    <= ST_D_SETUP;
        end
        ST_D_SETUP: begin
          bus_adr  <= ADR_DATA;
          bus_dout <= cur.data;
          bus_cs_n <= 1'b0;
          cnt      <= '0;
          state    <= ST_D_STROBE;
        end
        ST_D_STROBE: begin
          bus_cs_n <= 1'b0;
          bus_wr_n <= 1'b0;
          if (cnt == WR_LAST) state <= ST_D_HOLD;
          else                cnt   <= cnt + CNT_W'(1);
        end
        ST_D_HOLD: begin
          bus_cs_n <= 1'b0;
          cnt      <= '0;
          if (GAP != 0)  state <= ST_GAP;
          else if (pop_c) state <= ST_A_SETUP;
          else            state <= ST_IDLE;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) state <= pop_c ? ST_A_SETUP : ST_IDLE;
          else                 cnt   <= cnt + CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqm_bus_writer.sv
// tb_sqm_bus_writer: directed bench for sqm_bus_writer at default timing
// (dut_a) and at WR_WIDTH=1, GAP=0 (dut_b), with a PSG register-file model on dut_a.
module tb_sqm_bus_writer;
  import sqm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  // dut_a: defaults
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, bus_adr, bus_cs_n, bus_wr_n, busy;
  logic [7:0] bus_dout;

  // dut_b: fastest timing
  logic       b_reset = 1'b1;
  logic       b_valid = 1'b0;
  logic [3:0] b_reg = '0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_adr, b_cs_n, b_wr_n, b_busy;
  logic [7:0] b_dout;

  sqm_bus_writer #(.DEPTH(4), .WR_WIDTH(2), .GAP(8)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_reg(cmd_reg),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .bus_adr(bus_adr),
    .bus_dout(bus_dout), .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n), .busy(busy)
  );

  sqm_bus_writer #(.DEPTH(4), .WR_WIDTH(1), .GAP(0)) dut_b (
    .clk(clk), .reset(b_reset), .cmd_valid(b_valid), .cmd_reg(b_reg),
    .cmd_data(b_data), .cmd_ready(b_ready), .bus_adr(b_adr),
    .bus_dout(b_dout), .bus_cs_n(b_cs_n), .bus_wr_n(b_wr_n), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe-start log and bus-rule checks
  typedef struct {
    logic       adr;
    logic [7:0] dout;
    int         cyc;
  } wr_t;

  wr_t  wq_a[$];
  wr_t  wq_b[$];
  logic prev_wr_a = 1'b1, prev_adr_a = 1'b0;
  logic prev_wr_b = 1'b1, prev_adr_b = 1'b0;
  logic [7:0] prev_dout_a = '0, prev_dout_b = '0;

  always @(negedge clk) begin
    if (!bus_wr_n) begin
      check("a_wr_implies_cs", 32'(bus_cs_n), 32'(0));
      check("a_strobe_stable", 32'({bus_adr, bus_dout}), 32'({prev_adr_a, prev_dout_a}));
      if (prev_wr_a) wq_a.push_back('{adr: bus_adr, dout: bus_dout, cyc: cyc});
    end
    prev_wr_a   = bus_wr_n;
    prev_adr_a  = bus_adr;
    prev_dout_a = bus_dout;
  end

  always @(negedge clk) begin
    if (!b_wr_n) begin
      check("b_wr_implies_cs", 32'(b_cs_n), 32'(0));
      check("b_strobe_stable", 32'({b_adr, b_dout}), 32'({prev_adr_b, prev_dout_b}));
      if (prev_wr_b) wq_b.push_back('{adr: b_adr, dout: b_dout, cyc: cyc});
    end
    prev_wr_b   = b_wr_n;
    prev_adr_b  = b_adr;
    prev_dout_b = b_dout;
  end

  // PSG register file: index latch on adr=0 writes, register write on adr=1
  logic       psg_clear = 1'b0;
  logic [7:0] psg_regs [16];
  logic [3:0] psg_addr = '0;
  always @(posedge clk) begin
    if (psg_clear) begin
      for (int i = 0; i < 16; i++) psg_regs[i] <= 8'hAA;
    end else if (!bus_cs_n && !bus_wr_n) begin
      if (bus_adr == ADR_INDEX) psg_addr <= bus_dout[3:0];
      else                      psg_regs[psg_addr] <= bus_dout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted (bounded)
  task automatic push_a(input logic [3:0] r, input logic [7:0] d);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_reg   = r;
    cmd_data  = d;
    while (!cmd_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!cmd_ready) check("push_a_timeout", 32'(cmd_ready), 32'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input string name, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  // Per-cycle expected bus/busy values for a single command at default timing
  typedef struct packed {
    logic       adr;
    logic [7:0] dout;
    logic       cs_n;
    logic       wr_n;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(input logic adr, input logic [7:0] dout,
                              input logic cs_n, input logic wr_n, input logic bsy);
    vec_t v;
    v.adr = adr; v.dout = dout; v.cs_n = cs_n; v.wr_n = wr_n; v.busy = bsy;
    return v;
  endfunction

  vec_t       vt [17];
  vec_t       got;
  logic [3:0] sr [8];
  logic [7:0] sd [8];
  int         a0;
  int         n;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vt[0] = mk(1'b0, 8'h07, 1'b0, 1'b1, 1'b1);
    vt[1] = mk(1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
    vt[2] = mk(1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
    vt[3] = mk(1'b0, 8'h07, 1'b0, 1'b1, 1'b1);
    vt[4] = mk(1'b1, 8'h38, 1'b0, 1'b1, 1'b1);
    vt[5] = mk(1'b1, 8'h38, 1'b0, 1'b0, 1'b1);
    vt[6] = mk(1'b1, 8'h38, 1'b0, 1'b0, 1'b1);
    vt[7] = mk(1'b1, 8'h38, 1'b0, 1'b1, 1'b1);
    for (int i = 8; i < 16; i++) vt[i] = mk(1'b1, 8'h38, 1'b1, 1'b1, 1'b1);
    vt[16] = mk(1'b1, 8'h38, 1'b1, 1'b1, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_cs_n",  32'(bus_cs_n),  32'(1));
    check("rst_wr_n",  32'(bus_wr_n),  32'(1));
    check("rst_adr",   32'(bus_adr),   32'(0));
    check("rst_dout",  32'(bus_dout),  32'(0));
    check("rst_busy",  32'(busy),      32'(0));
    check("rst_ready", 32'(cmd_ready), 32'(1));
    reset   = 1'b0;
    b_reset = 1'b0;
    tick();

    // Single command, cycle-by-cycle
    push_a(4'd7, 8'h38);
    check("single_busy_early", 32'(busy), 32'(0));
    tick();
    check("single_pre_setup_cs", 32'(bus_cs_n), 32'(1));
    check("single_busy_rise", 32'(busy), 32'(1));
    tick();
    for (int i = 0; i < 17; i++) begin
      got = {bus_adr, bus_dout, bus_cs_n, bus_wr_n, busy};
      check($sformatf("single_vec%0d", i), 32'(got), 32'(vt[i]));
      tick();
    end

    // Five back-to-back commands into a 4-deep FIFO
    wq_a.delete();
    for (int k = 0; k < 5; k++) begin
      sr[k] = 4'(k + 1);
      sd[k] = 8'(8'h40 + 8'(k * 17));
    end
    for (int k = 0; k < 5; k++) push_a(sr[k], sd[k]);
    check("fill_ready_low", 32'(cmd_ready), 32'(0));
    wait_idle_a("fill_idle", 200);
    check("fill_count", 32'(wq_a.size()), 32'(10));
    for (int k = 0; k < 5 && 2 * k + 1 < wq_a.size(); k++) begin
      check($sformatf("fill_idx%0d", k),  32'({wq_a[2*k].adr, wq_a[2*k].dout}),     32'({1'b0, 4'h0, sr[k]}));
      check($sformatf("fill_data%0d", k), 32'({wq_a[2*k+1].adr, wq_a[2*k+1].dout}), 32'({1'b1, sd[k]}));
      if (k > 0)
        check($sformatf("fill_spacing%0d", k), 32'(wq_a[2*k].cyc - wq_a[2*k-2].cyc), 32'(16));
    end

    // Eight commands with pushes landing on pop edges at occupancy 3
    wq_a.delete();
    for (int k = 0; k < 8; k++) begin
      sr[k] = 4'(15 - k);
      sd[k] = 8'(8'h81 + 8'(k * 5));
    end
    push_a(sr[0], sd[0]);
    a0 = cyc;
    for (int k = 1; k < 4; k++) push_a(sr[k], sd[k]);
    for (int k = 4; k < 8; k++) begin
      while (cyc < a0 + 16 * (k - 3)) tick();
      check($sformatf("ovl_ready_pre%0d", k), 32'(cmd_ready), 32'(1));
      push_a(sr[k], sd[k]);
      check($sformatf("ovl_ready_post%0d", k), 32'(cmd_ready), 32'(1));
    end
    wait_idle_a("ovl_idle", 200);
    check("ovl_count", 32'(wq_a.size()), 32'(16));
    for (int k = 0; k < 8 && 2 * k + 1 < wq_a.size(); k++) begin
      check($sformatf("ovl_idx%0d", k),  32'({wq_a[2*k].adr, wq_a[2*k].dout}),     32'({1'b0, 4'h0, sr[k]}));
      check($sformatf("ovl_data%0d", k), 32'({wq_a[2*k+1].adr, wq_a[2*k+1].dout}), 32'({1'b1, sd[k]}));
    end

    // Reset asserted during the data strobe
    push_a(4'd2, 8'h55);
    push_a(4'd3, 8'h66);
    push_a(4'd4, 8'h77);
    n = 0;
    while (!(!bus_wr_n && bus_adr) && n < 60) begin
      tick();
      n++;
    end
    check("rst_dstrobe_reached", 32'({bus_wr_n, bus_adr}), 32'(2'b01));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wr_n",  32'(bus_wr_n),  32'(1));
    check("rst_mid_cs_n",  32'(bus_cs_n),  32'(1));
    check("rst_mid_busy",  32'(busy),      32'(0));
    check("rst_mid_ready", 32'(cmd_ready), 32'(1));
    tick();
    reset = 1'b0;
    wq_a.delete();
    repeat (30) tick();
    check("rst_discard_writes", 32'(wq_a.size()), 32'(0));
    check("rst_discard_busy",   32'(busy),        32'(0));

    // First command after reset
    push_a(4'hA, 8'h5A);
    tick();
    check("post_rst_pre_setup", 32'(bus_cs_n), 32'(1));
    tick();
    check("post_rst_setup", 32'({bus_adr, bus_dout, bus_cs_n, bus_wr_n}), 32'({1'b0, 8'h0A, 1'b0, 1'b1}));
    wait_idle_a("post_rst_idle", 40);

    // PSG register-file model
    psg_clear = 1'b1;
    tick();
    psg_clear = 1'b0;
    push_a(4'd0, 8'h10);
    push_a(4'd1, 8'h00);
    push_a(4'd8, 8'h0F);
    wait_idle_a("psg_idle", 100);
    check("psg_r0", 32'(psg_regs[0]), 32'(8'h10));
    check("psg_r1", 32'(psg_regs[1]), 32'(8'h00));
    check("psg_r8", 32'(psg_regs[8]), 32'(8'h0F));
    check("psg_r2_untouched", 32'(psg_regs[2]), 32'(8'hAA));

    // WR_WIDTH=1, GAP=0: two commands, 6-cycle spacing
    wq_b.delete();
    check("b_ready0", 32'(b_ready), 32'(1));
    b_valid = 1'b1; b_reg = 4'd3; b_data = 8'hC3;
    tick();
    check("b_ready1", 32'(b_ready), 32'(1));
    b_reg = 4'd4; b_data = 8'h44;
    tick();
    b_valid = 1'b0;
    n = 0;
    while (b_busy && n < 60) begin
      tick();
      n++;
    end
    check("b_idle", 32'(b_busy), 32'(0));
    check("b_count", 32'(wq_b.size()), 32'(4));
    if (wq_b.size() >= 4) begin
      check("b_idx0",  32'({wq_b[0].adr, wq_b[0].dout}), 32'({1'b0, 8'h03}));
      check("b_data0", 32'({wq_b[1].adr, wq_b[1].dout}), 32'({1'b1, 8'hC3}));
      check("b_idx1",  32'({wq_b[2].adr, wq_b[2].dout}), 32'({1'b0, 8'h04}));
      check("b_data1", 32'({wq_b[3].adr, wq_b[3].dout}), 32'({1'b1, 8'h44}));
      check("b_idx_to_data", 32'(wq_b[1].cyc - wq_b[0].cyc), 32'(3));
      check("b_spacing",     32'(wq_b[2].cyc - wq_b[0].cyc), 32'(6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
